hazard_tracker: RTL and testbench

Parametrised forwarding and stall unit for the pipelined CPU. It tracks every in-flight register writer and its result latency in a shift-register scoreboard, so it handles variable-latency producers such as ALU, load and multi-cycle ops, and any number of source operands. At issue it resolves each source operand of the instruction in ID to a bypass stage or to the register file, and requests a stall when a producer's result will not be ready by EX. Its outputs are registered into EX alongside the instruction and drive the EX operand bypass muxes.

---
 rtl/hazard_tracker.sv | 109 ++++++++++
 tb/tb_hazard_tracker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// hazard_tracker: resolves ID source operands to a bypass stage or the register file; requests load-use stalls.
// Latency: stall is combinational in ID; ex_fwd_sel is registered and valid for the whole EX cycle of its instruction.
// Backpressure: stall holds PC and IF/ID and bubbles EX; hold freezes all state; flush kills ID and EX.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   hold, flush         pipeline freeze / branch redirect kill of ID and EX
//   id_valid, id_rs, id_rs_used, id_rd, id_we, id_lat
//                       instruction in ID: sources, destination, result latency
//   stall               combinational stall request
//   ex_fwd_sel          per-operand bypass select for EX (0 = register file, k = stage k)
//   stall_count         saturating count of stall cycles
module hazard_tracker #(
  parameter int DEPTH   = 3,
  parameter int NUM_SRC = 2,
  parameter int LAT_W   = 2,
  parameter int SEL_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hold,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [NUM_SRC*5-1:0]     id_rs,
  input  logic [NUM_SRC-1:0]       id_rs_used,
  input  logic [4:0]               id_rd,
  input  logic                     id_we,
  input  logic [LAT_W-1:0]         id_lat,
  output logic                     stall,
  output logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel,
  output logic [15:0]              stall_count
);

  // Scoreboard, stage 0 = EX ... stage DEPTH-1 = WB. Latency is kept SEL_W wide:
  // after clamping it never exceeds DEPTH-1, which always fits.
  logic [DEPTH-1:0]            sb_valid;
  logic [DEPTH-1:0][4:0]       sb_rd;
  logic [DEPTH-1:0][SEL_W-1:0] sb_lat;

  logic [DEPTH-1:0]         shifted_valid;
  logic [NUM_SRC*SEL_W-1:0] res_sel;
  logic [NUM_SRC-1:0]       not_ready;
  logic                     id_alloc;
  logic [SEL_W-1:0]         id_lat_eff;

  assign id_alloc      = id_we && (id_rd != 5'd0);
  assign id_lat_eff    = ((id_lat == '0) || (32'(id_lat) >= DEPTH)) ? SEL_W'(DEPTH - 1) : SEL_W'(id_lat);
  assign shifted_valid = {sb_valid[DEPTH-2:0], 1'b0};

  // Walk from oldest to youngest so the youngest matching producer is the
  // last one written and therefore wins.
  always_comb begin
    res_sel   = '0;
    not_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if (id_valid && id_rs_used[i] && sb_valid[s] &&
            (id_rs[5*i +: 5] != 5'd0) && (sb_rd[s] == id_rs[5*i +: 5])) begin
          if (s == DEPTH - 1) begin
            // Producer is in WB now and will have written the register file
            // by the time the consumer is in EX.
            res_sel[i*SEL_W +: SEL_W] = '0;
            not_ready[i]              = 1'b0;
          end else if ((s + 1) >= int'(sb_lat[s])) begin
            res_sel[i*SEL_W +: SEL_W] = SEL_W'(s + 1);
            not_ready[i]              = 1'b0;
          end else begin
            res_sel[i*SEL_W +: SEL_W] = '0;
            not_ready[i]              = 1'b1;
          end
        end
      end
    end
  end

  assign stall = id_valid && (|not_ready) && !flush;

  // rd/lat always shift in the ID values; only the valid bit decides whether
  // stage 0 holds a real writer or a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_valid    <= '0;
      sb_rd       <= '0;
      sb_lat      <= '0;
      ex_fwd_sel  <= '0;
      stall_count <= '0;
    end else if (flush) begin
      // Old stage 0 (instruction in EX) is killed as it moves to stage 1.
      sb_valid   <= shifted_valid & ~DEPTH'(2);
      sb_rd      <= {sb_rd[DEPTH-2:0], id_rd};
      sb_lat     <= {sb_lat[DEPTH-2:0], id_lat_eff};
      ex_fwd_sel <= '0;
    end else if (!hold) begin
      sb_rd  <= {sb_rd[DEPTH-2:0], id_rd};
      sb_lat <= {sb_lat[DEPTH-2:0], id_lat_eff};
      if (stall) begin
        sb_valid   <= shifted_valid;
        ex_fwd_sel <= '0;
        if (stall_count != 16'hFFFF) begin
          stall_count <= stall_count + 16'd1;
        end
      end else begin
        sb_valid   <= {sb_valid[DEPTH-2:0], id_valid && id_alloc};
        ex_fwd_sel <= id_valid ? res_sel : '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: directed vector table and corner sequences on a
// DEPTH=3 instance, a DEPTH=5 parametric sequence, counter saturation on a
// DEPTH=32 instance, and randomized traffic against an in-flight writer list.
module tb_hazard_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, hold, flush, id_valid, id_we;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used;
  logic [4:0] id_rd;
  logic [4:0] lat_in;

  logic        stall3, stall5, stall32;
  logic [3:0]  sel3;
  logic [5:0]  sel5;
  logic [9:0]  sel32;
  logic [15:0] cnt3, cnt5, cnt32;

  hazard_tracker #(.DEPTH(3), .NUM_SRC(2), .LAT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rd(id_rd), .id_we(id_we),
    .id_lat(lat_in[1:0]), .stall(stall3), .ex_fwd_sel(sel3), .stall_count(cnt3));

  hazard_tracker #(.DEPTH(5), .NUM_SRC(2), .LAT_W(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rd(id_rd), .id_we(id_we),
    .id_lat(lat_in[2:0]), .stall(stall5), .ex_fwd_sel(sel5), .stall_count(cnt5));

  hazard_tracker #(.DEPTH(32), .NUM_SRC(2), .LAT_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rd(id_rd), .id_we(id_we),
    .id_lat(lat_in), .stall(stall32), .ex_fwd_sel(sel32), .stall_count(cnt32));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic h, input logic f, input logic v, input logic [4:0] rs0,
                       input logic [4:0] rs1, input logic [1:0] used, input logic [4:0] rd,
                       input logic we, input logic [4:0] lat);
    hold = h; flush = f; id_valid = v; id_rs = {rs1, rs0}; id_rs_used = used;
    id_rd = rd; id_we = we; lat_in = lat;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table (DEPTH=3) ----------------
  typedef struct {
    logic       h, f, v;
    logic [4:0] rs0, rs1;
    logic [1:0] used;
    logic [4:0] rd;
    logic       we;
    logic [4:0] lat;
    logic       e_stall;
    int         e_s0, e_s1, e_cnt;
  } vec_t;

  localparam int NV = 23;
  vec_t vt [NV];

  function automatic vec_t mkv(input logic h, input logic f, input logic v, input int rs0,
                               input int rs1, input int used, input int rd, input logic we,
                               input int lat, input logic es, input int s0, input int s1,
                               input int c);
    vec_t r;
    r.h = h; r.f = f; r.v = v; r.rs0 = 5'(rs0); r.rs1 = 5'(rs1); r.used = 2'(used);
    r.rd = 5'(rd); r.we = we; r.lat = 5'(lat); r.e_stall = es; r.e_s0 = s0; r.e_s1 = s1; r.e_cnt = c;
    return r;
  endfunction

  // ---------------- reference model: list of in-flight writers ----------------
  localparam int MD = 3;
  typedef struct { int rd; int lat; int age; } wr_t;
  wr_t mq[$];
  int  m_cnt, m_sel0, m_sel1;

  function automatic int eff_lat(input int l);
    if (l == 0 || l >= MD) return MD - 1;
    return l;
  endfunction

  // Newest writer of rs decides: age+1 is its stage when the consumer is in EX.
  task automatic resolve(input int rs, input bit use_it, output int sel, output bit nr);
    int best;
    sel = 0; nr = 0; best = -1;
    if (id_valid && use_it && rs != 0) begin
      for (int k = 0; k < mq.size(); k++)
        if (mq[k].rd == rs && (best < 0 || mq[k].age < mq[best].age)) best = k;
      if (best >= 0) begin
        if (mq[best].age + 1 > MD - 1) sel = 0;
        else if (mq[best].age + 1 >= mq[best].lat) sel = mq[best].age + 1;
        else nr = 1;
      end
    end
  endtask

  task automatic age_all(input bit kill_ex);
    wr_t nq[$];
    for (int k = 0; k < mq.size(); k++) begin
      if (!(kill_ex && mq[k].age == 0) && mq[k].age + 1 < MD)
        nq.push_back('{rd: mq[k].rd, lat: mq[k].lat, age: mq[k].age + 1});
    end
    mq = nq;
  endtask

  task automatic model_clock(input bit st, input int s0, input int s1);
    if (!rst_n) begin
      mq.delete(); m_cnt = 0; m_sel0 = 0; m_sel1 = 0;
    end else if (flush) begin
      age_all(1); m_sel0 = 0; m_sel1 = 0;
    end else if (!hold) begin
      age_all(0);
      if (st) begin
        m_sel0 = 0; m_sel1 = 0;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        if (id_valid && id_we && id_rd != 5'd0)
          mq.push_back('{rd: int'(id_rd), lat: eff_lat(int'(lat_in[1:0])), age: 0});
        m_sel0 = id_valid ? s0 : 0;
        m_sel1 = id_valid ? s1 : 0;
      end
    end
  endtask

  initial begin
    int  s0, s1;
    bit  nr0, nr1, es;

    vt[0]  = mkv(0,0,1,  1, 2,3,  5,1,1, 0,0,0,0);  // add x5
    vt[1]  = mkv(0,0,1,  5, 5,3,  6,1,1, 0,1,1,0);  // sub x6,x5,x5
    vt[2]  = mkv(0,0,1,  1, 0,1,  7,1,2, 0,0,0,0);  // lw x7
    vt[3]  = mkv(0,0,1,  7, 0,3,  8,1,1, 1,0,0,1);  // add x8,x7,x0 stalls
    vt[4]  = mkv(0,0,1,  7, 0,3,  8,1,1, 0,2,0,1);  // issues with sel 2
    vt[5]  = mkv(0,0,1,  0, 0,1,  3,1,1, 0,0,0,1);  // addi x3
    vt[6]  = mkv(0,0,1,  0, 0,1,  3,1,1, 0,0,0,1);  // addi x3
    vt[7]  = mkv(0,0,1,  3, 3,3,  4,1,1, 0,1,1,1);  // youngest x3 wins
    vt[8]  = mkv(0,0,1,  0, 0,0,  0,0,1, 0,0,0,1);  // nop
    vt[9]  = mkv(0,0,1,  4, 0,1, 10,1,1, 0,2,0,1);  // x4 two back
    vt[10] = mkv(0,0,1,  4, 4,3,  9,1,1, 0,0,0,1);  // x4 in WB -> regfile
    vt[11] = mkv(0,0,1,  0, 0,0,  0,1,2, 0,0,0,1);  // writer to x0
    vt[12] = mkv(0,0,1,  0, 0,3,  0,0,1, 0,0,0,1);  // read x0
    vt[13] = mkv(0,0,1,  0, 0,0, 11,1,2, 0,0,0,1);  // lw x11
    vt[14] = mkv(0,0,1, 11,11,0,  0,0,1, 0,0,0,1);  // x11 not used
    vt[15] = mkv(0,0,1, 11, 0,1,  0,0,1, 0,2,0,1);
    vt[16] = mkv(0,0,0, 11, 0,1,  0,0,1, 0,0,0,1);  // invalid ID
    vt[17] = mkv(0,0,1,  0, 0,0, 12,1,2, 0,0,0,1);  // lw x12
    vt[18] = mkv(0,1,1, 12, 0,1, 13,1,1, 0,0,0,1);  // flush kills load
    vt[19] = mkv(0,0,1, 12, 0,1, 13,1,1, 0,0,0,1);  // no stall after flush
    vt[20] = mkv(0,0,1,  0, 0,0, 14,1,3, 0,0,0,1);  // lat 3 clamps to 2
    vt[21] = mkv(0,0,1, 14, 0,1,  0,0,1, 1,0,0,2);
    vt[22] = mkv(0,0,1, 14, 0,1,  0,0,1, 0,2,0,2);

    // Reset state
    do_reset();
    @(negedge clk);
    chk("reset stall", stall3, 0);
    chk("reset sel", sel3, 0);
    chk("reset cnt", cnt3, 0);
    chk("reset cnt5", cnt5, 0);
    chk("reset cnt32", cnt32, 0);
    do_reset();

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].h, vt[i].f, vt[i].v, vt[i].rs0, vt[i].rs1, vt[i].used, vt[i].rd, vt[i].we, vt[i].lat);
      @(negedge clk);
      chk($sformatf("vec%0d stall", i), stall3, vt[i].e_stall);
      tick();
      chk($sformatf("vec%0d sel0", i), sel3[1:0], vt[i].e_s0);
      chk($sformatf("vec%0d sel1", i), sel3[3:2], vt[i].e_s1);
      chk($sformatf("vec%0d cnt", i), cnt3, vt[i].e_cnt);
    end

    // Hold for 3 cycles during a load-use stall
    do_reset();
    drive(0, 0, 1, 0, 0, 2'b00, 7, 1, 2);
    tick();
    drive(1, 0, 1, 7, 0, 2'b01, 8, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold stall", stall3, 1);
      tick();
      chk("hold cnt", cnt3, 0);
      chk("hold sel", sel3, 0);
    end
    hold = 1'b0;
    @(negedge clk);
    chk("post-hold stall", stall3, 1);
    tick();
    chk("post-hold cnt", cnt3, 1);
    @(negedge clk);
    chk("post-hold issue", stall3, 0);
    tick();
    chk("post-hold sel0", sel3[1:0], 2);

    // Reset in the middle of a stall
    do_reset();
    drive(0, 0, 1, 0, 0, 2'b00, 7, 1, 2);
    tick();
    drive(0, 0, 1, 7, 0, 2'b01, 8, 1, 1);
    @(negedge clk);
    chk("pre-reset stall", stall3, 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("after-reset stall", stall3, 0);
    chk("after-reset cnt", cnt3, 0);
    tick();

    // DEPTH=5, lat 4 producer then dependent: 3 stalls then sel 4
    do_reset();
    drive(0, 0, 1, 0, 0, 2'b00, 5, 1, 4);
    tick();
    drive(0, 0, 1, 5, 0, 2'b01, 6, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("d5 stall", stall5, 1);
      tick();
    end
    @(negedge clk);
    chk("d5 issue", stall5, 0);
    tick();
    chk("d5 sel0", sel5[2:0], 4);
    chk("d5 cnt", cnt5, 3);

    // Randomized traffic against the reference model (DEPTH=3 instance)
    for (int n = 0; n < 2000; n++) begin
      rst_n      = (n == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      hold       = ($urandom_range(0, 9) == 0);
      flush      = ($urandom_range(0, 14) == 0);
      id_valid   = ($urandom_range(0, 4) != 0);
      id_rs      = {5'($urandom_range(0, 6)), 5'($urandom_range(0, 6))};
      id_rs_used = 2'($urandom_range(0, 3));
      id_rd      = 5'($urandom_range(0, 6));
      id_we      = 1'($urandom_range(0, 1));
      lat_in     = 5'($urandom_range(0, 3));
      resolve(int'(id_rs[4:0]), id_rs_used[0], s0, nr0);
      resolve(int'(id_rs[9:5]), id_rs_used[1], s1, nr1);
      es = id_valid && (nr0 || nr1) && !flush;
      @(negedge clk);
      if (n > 0) chk("rnd stall", stall3, 32'(es));
      @(posedge clk);
      model_clock(es, s0, s1);
      #1;
      chk("rnd sel0", sel3[1:0], m_sel0);
      chk("rnd sel1", sel3[3:2], m_sel1);
      chk("rnd cnt", cnt3, m_cnt);
    end
    rst_n = 1'b1;

    // Counter saturation on DEPTH=32: each lat-31 self-dependent op costs 30 stalls
    do_reset();
    drive(0, 0, 1, 1, 0, 2'b01, 1, 1, 31);
    repeat (31) @(posedge clk);
    #1;
    chk("d32 cnt period", cnt32, 30);
    tick();
    chk("d32 sel0", sel32[4:0], 31);
    chk("d32 sel1", sel32[9:5], 0);
    repeat (67800) @(posedge clk);
    #1;
    chk("d32 saturated", cnt32, 16'hFFFF);
    repeat (31) @(posedge clk);
    @(negedge clk);
    chk("d32 still stalling", stall32, 1);
    chk("d32 stays saturated", cnt32, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
